// File: rtl/comparator_pkg.sv
// Shared types and helpers for the sequential slice-wise magnitude comparator.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } cmp_state_e;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_result_t;

  // Width needed to hold a slice count in the range 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational compare of one CHUNK-bit slice; invert_msb turns the slice
// MSB into an offset-binary sign bit so a signed top slice compares unsigned.
module comparator_chunk
  import comparator_pkg::*;
#(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_s,
  input  logic [CHUNK-1:0] b_s,
  input  logic             invert_msb,
  output cmp_result_t      res
);

  logic [CHUNK-1:0] flip;
  logic [CHUNK-1:0] a_eff;
  logic [CHUNK-1:0] b_eff;

  assign flip  = CHUNK'(invert_msb) << (CHUNK - 1);
  assign a_eff = a_s ^ flip;
  assign b_eff = b_s ^ flip;

  always_comb begin
    res    = '0;
    res.eq = (a_eff == b_eff);
    res.gt = (a_eff >  b_eff);
    res.lt = (a_eff <  b_eff);
  end

endmodule

// File: rtl/comparator_nbit_seq.sv
// Multi-cycle magnitude comparator: latches operands on a start handshake,
// walks slices MSB-first with early exit, and holds a one-hot result until taken.
module comparator_nbit_seq
  import comparator_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4,
  localparam int unsigned NCHUNK = WIDTH / CHUNK,
  localparam int unsigned CW = cnt_width(NCHUNK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             A_eq_B,
  output logic             A_gt_B,
  output logic             A_lt_B,
  output logic [CW-1:0]    cycles
);

  localparam int unsigned IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0 || CHUNK == 0) begin : g_bad_params
    $error("comparator_nbit_seq: WIDTH must be a non-zero multiple of CHUNK");
  end

  cmp_state_e       state, state_d;
  logic [IW-1:0]    idx, idx_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  cmp_result_t      res_q, res_d;
  logic [CW-1:0]    cycles_d;
  logic             start_ready_d, res_valid_d;

  logic [CHUNK-1:0] a_s, b_s;
  logic             invert_msb;
  cmp_result_t      slice;

  // Slice mux: only the top slice carries the sign bit.
  assign a_s        = a_q[32'(idx) * CHUNK +: CHUNK];
  assign b_s        = b_q[32'(idx) * CHUNK +: CHUNK];
  assign invert_msb = sgn_q && (idx == IW'(NCHUNK - 1));

  comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_s        (a_s),
    .b_s        (b_s),
    .invert_msb (invert_msb),
    .res        (slice)
  );

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    cnt_d    = cnt;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    res_d    = res_q;
    cycles_d = cycles;
    case (state)
      IDLE: begin
        if (start_valid && start_ready) begin
          a_d     = A;
          b_d     = B;
          sgn_d   = is_signed;
          idx_d   = IW'(NCHUNK - 1);
          cnt_d   = '0;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        cnt_d = cnt + CW'(1);
        // A differing slice or the last equal slice both settle the answer.
        if (!slice.eq || idx == '0) begin
          res_d    = slice;
          cycles_d = cnt + CW'(1);
          state_d  = DONE;
        end else begin
          idx_d = idx - IW'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          res_d    = '0;
          cycles_d = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    start_ready_d = (state_d == IDLE);
    res_valid_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      res_q       <= '0;
      cycles      <= '0;
      start_ready <= 1'b1;
      res_valid   <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      cnt         <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sgn_q       <= sgn_d;
      res_q       <= res_d;
      cycles      <= cycles_d;
      start_ready <= start_ready_d;
      res_valid   <= res_valid_d;
    end
  end

  assign A_eq_B = res_q.eq;
  assign A_gt_B = res_q.gt;
  assign A_lt_B = res_q.lt;

endmodule

// File: tb/tb_comparator_nbit_seq.sv
// Self-checking bench: directed cases plus randomized operations against a
// plain-arithmetic reference model of the comparator.
module tb_comparator_nbit_seq;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CHUNK  = 4;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = $clog2(NCHUNK + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             res_valid;
  logic             res_ready;
  logic             a_eq_b, a_gt_b, a_lt_b;
  logic [CW-1:0]    cycles;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  comparator_nbit_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .A           (a),
    .B           (b),
    .is_signed   (is_signed),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .A_eq_B      (a_eq_b),
    .A_gt_B      (a_gt_b),
    .A_lt_B      (a_lt_b),
    .cycles      (cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: magnitude order from integer compare; slice count from the
  // highest slice in which the raw operands differ.
  task automatic model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                       input logic s, output logic [2:0] flags, output int cyc);
    logic gt, lt;
    if (s) begin
      gt = $signed(ma) > $signed(mb);
      lt = $signed(ma) < $signed(mb);
    end else begin
      gt = ma > mb;
      lt = ma < mb;
    end
    flags = {(ma == mb), gt, lt};
    cyc = NCHUNK;
    for (int i = NCHUNK - 1; i >= 0; i--) begin
      if (((ma >> (i * CHUNK)) & 16'hF) != ((mb >> (i * CHUNK)) & 16'hF)) begin
        cyc = NCHUNK - i;
        break;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_flags"}, 32'({a_eq_b, a_gt_b, a_lt_b}), 32'd0);
    chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
  endtask

  // One full operation; hold = cycles res_ready stays low in DONE.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] oa,
                       input logic [WIDTH-1:0] ob, input logic s, input int hold);
    logic [2:0] ef;
    int ec, lat;
    model(oa, ob, s, ef, ec);
    @(negedge clk);
    a = oa; b = ob; is_signed = s; start_valid = 1'b1; res_ready = 1'b0;
    chk({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); is_signed = 1'($urandom);
    lat = 0;
    while (lat < 20) begin
      res_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      if (res_valid) break;
    end
    res_ready = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(ec));
    chk({tag, "_flags"}, 32'({a_eq_b, a_gt_b, a_lt_b}), 32'(ef));
    chk({tag, "_cycles"}, 32'(cycles), 32'(ec));
    chk({tag, "_busy"}, 32'(start_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      start_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(posedge clk); #1;
      start_valid = 1'b0;
      chk({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
      chk({tag, "_hold_flags"}, 32'({a_eq_b, a_gt_b, a_lt_b}), 32'(ef));
      chk({tag, "_hold_cycles"}, 32'(cycles), 32'(ec));
      chk({tag, "_hold_busy"}, 32'(start_ready), 32'd0);
    end
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_idle_outputs({tag, "_after"});
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; is_signed = 1'b0;
    #12;
    check_idle_outputs("reset");
    chk("reset_cycles", 32'(cycles), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op("eq_1234",   16'h1234, 16'h1234, 1'b0, 0);
    do_op("u_a000",    16'hA000, 16'h5000, 1'b0, 0);
    do_op("s_a000",    16'hA000, 16'h5000, 1'b1, 0);
    do_op("u_1235",    16'h1235, 16'h1236, 1'b0, 0);
    do_op("u_1334",    16'h1334, 16'h1234, 1'b0, 0);
    do_op("s_ffff",    16'hFFFF, 16'h0000, 1'b1, 0);
    do_op("s_8000",    16'h8000, 16'h8001, 1'b1, 0);
    do_op("backpress", 16'h00F0, 16'h00E0, 1'b0, 3);

    // Abort during the second compare cycle.
    @(negedge clk);
    a = 16'h1234; b = 16'h1234; is_signed = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1; start_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check_idle_outputs("rst_compare");
    chk("rst_compare_cycles", 32'(cycles), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_release_ready", 32'(start_ready), 32'd1);

    // Abort while a result is held in DONE.
    @(negedge clk);
    a = 16'hA000; b = 16'h5000; start_valid = 1'b1;
    @(posedge clk); #1; start_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_done_pre_valid", 32'(res_valid), 32'd1);
    #2 rst_n = 1'b0; #1;
    check_idle_outputs("rst_done");
    chk("rst_done_cycles", 32'(cycles), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op("post_rst", 16'h0001, 16'h0000, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: rb = ra ^ (WIDTH'($urandom_range(1, 15)) << (CHUNK * $urandom_range(0, NCHUNK - 1)));
        default: rb = WIDTH'($urandom);
      endcase
      do_op($sformatf("rand%0d", n), ra, rb, 1'($urandom), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
